// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired T-state control unit: fetch, decode, ALU/unary/MUL-DIV execute
// Optional memory-wait stall in T1 enabled by defining CU_MEM_WAIT_EN.
module control_sequencer #(
    parameter int NREG = 16,
    parameter int OPW  = 5
) (
    input  logic            Clock_i,
    input  logic            Clear_i,
    input  logic [31:0]     IR_i,
    input  logic            MemReady_i,
    output logic            Run_o,
    output logic [3:0]      State_o,
    output logic            PCout_o,
    output logic            PCin_o,
    output logic            IncPC_o,
    output logic            MARin_o,
    output logic            MDRin_o,
    output logic            MDRout_o,
    output logic            Read_o,
    output logic            IRin_o,
    output logic            Yin_o,
    output logic            ZLowin_o,
    output logic            ZHighin_o,
    output logic            ZLowout_o,
    output logic            ZHighout_o,
    output logic            HIin_o,
    output logic            LOin_o,
    output logic            HIout_o,
    output logic            LOout_o,
    output logic [NREG-1:0] Rin_o,
    output logic [NREG-1:0] Rout_o,
    output logic [OPW-1:0]  OP_o
);
    typedef enum logic [3:0] {
        S_RST  = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
        S_T4   = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_HALT = 4'd8
    } state_t;

    localparam logic [4:0] OPC_ADD = 5'b00011, OPC_SUB = 5'b00100, OPC_AND = 5'b00101,
                           OPC_OR  = 5'b00110, OPC_MUL = 5'b01111, OPC_DIV = 5'b10000,
                           OPC_NEG = 5'b10001, OPC_NOT = 5'b10010, OPC_HLT = 5'b11011;

    state_t     state_q;
    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       is_alu2, is_unary, is_muldiv, mem_ok;

    assign opcode    = IR_i[31:27];
    assign ra        = IR_i[26:23];
    assign rb        = IR_i[22:19];
    assign rc        = IR_i[18:15];
    assign is_alu2   = (opcode == OPC_ADD) || (opcode == OPC_SUB) ||
                       (opcode == OPC_AND) || (opcode == OPC_OR);
    assign is_unary  = (opcode == OPC_NEG) || (opcode == OPC_NOT);
    assign is_muldiv = (opcode == OPC_MUL) || (opcode == OPC_DIV);

`ifdef CU_MEM_WAIT_EN
    assign mem_ok = MemReady_i;
    logic unused_bits;
    assign unused_bits = ^IR_i[14:0];
`else
    assign mem_ok = 1'b1;
    logic unused_bits;
    assign unused_bits = ^{MemReady_i, IR_i[14:0]};
`endif

    function automatic logic [NREG-1:0] onehot(input logic [3:0] f);
        logic [NREG-1:0] r;
        for (int i = 0; i < NREG; i++) r[i] = (int'(f) == i);
        return r;
    endfunction

    function automatic logic [OPW-1:0] op_map(input logic [4:0] opc);
        case (opc)
            OPC_SUB: return OPW'(5'b00001);
            OPC_NOT: return OPW'(5'b00010);
            OPC_AND: return OPW'(5'b00011);
            OPC_OR:  return OPW'(5'b00100);
            OPC_NEG: return OPW'(5'b00101);
            OPC_MUL: return OPW'(5'b01000);
            OPC_DIV: return OPW'(5'b01001);
            default: return OPW'(5'b00000);
        endcase
    endfunction

    // Decode in T2 and later follows whatever IR holds in that cycle; undefined opcodes fall back to fetch.
    always_ff @(posedge Clock_i) begin
        if (Clear_i) begin
            state_q <= S_RST;
        end else begin
            case (state_q)
                S_RST:  state_q <= S_T0;
                S_T0:   state_q <= S_T1;
                S_T1:   state_q <= mem_ok ? S_T2 : S_T1;
                S_T2:   state_q <= (opcode == OPC_HLT) ? S_HALT :
                                   (is_alu2 || is_unary || is_muldiv) ? S_T3 : S_T0;
                S_T3:   state_q <= S_T4;
                S_T4:   state_q <= (is_alu2 || is_muldiv) ? S_T5 : S_T0;
                S_T5:   state_q <= is_muldiv ? S_T6 : S_T0;
                S_T6:   state_q <= S_T0;
                S_HALT: state_q <= S_HALT;
                default: state_q <= S_RST;
            endcase
        end
    end

    always_comb begin
        Run_o = (state_q != S_HALT);
        State_o = state_q;
        {PCout_o, PCin_o, IncPC_o, MARin_o, MDRin_o, MDRout_o, Read_o, IRin_o, Yin_o} = '0;
        {ZLowin_o, ZHighin_o, ZLowout_o, ZHighout_o, HIin_o, LOin_o, HIout_o, LOout_o} = '0;
        Rin_o  = '0;
        Rout_o = '0;
        OP_o   = '0;
        case (state_q)
            S_T0: begin
                PCout_o = 1'b1; MARin_o = 1'b1; IncPC_o = 1'b1; ZLowin_o = 1'b1;
            end
            S_T1: begin
                Read_o = 1'b1; MDRin_o = 1'b1;
                ZLowout_o = mem_ok; PCin_o = mem_ok;
            end
            S_T2: begin
                MDRout_o = 1'b1; IRin_o = 1'b1;
            end
            S_T3: begin
                if (is_alu2) begin
                    Rout_o = onehot(rb); Yin_o = 1'b1;
                end else if (is_unary) begin
                    Rout_o = onehot(rb); OP_o = op_map(opcode); ZLowin_o = 1'b1;
                end else if (is_muldiv) begin
                    Rout_o = onehot(ra); Yin_o = 1'b1;
                end
            end
            S_T4: begin
                if (is_alu2) begin
                    Rout_o = onehot(rc); OP_o = op_map(opcode); ZLowin_o = 1'b1;
                end else if (is_unary) begin
                    ZLowout_o = 1'b1; Rin_o = onehot(ra);
                end else if (is_muldiv) begin
                    Rout_o = onehot(rb); OP_o = op_map(opcode);
                    ZLowin_o = 1'b1; ZHighin_o = 1'b1;
                end
            end
            S_T5: begin
                if (is_alu2) begin
                    ZLowout_o = 1'b1; Rin_o = onehot(ra);
                end else if (is_muldiv) begin
                    ZLowout_o = 1'b1; LOin_o = 1'b1;
                end
            end
            S_T6: begin
                if (is_muldiv) begin
                    ZHighout_o = 1'b1; HIin_o = 1'b1;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed self-checking bench for control_sequencer
module tb_control_sequencer;
    logic        clk = 1'b0;
    logic        clear = 1'b1;
    logic [31:0] ir = 32'h0;
    logic        mem_ready = 1'b1;
    logic        run, pcout, pcin, incpc, marin, mdrin, mdrout, rd, irin, yin;
    logic        zlin, zhin, zlout, zhout, hiin, loin, hiout, loout;
    logic [3:0]  state;
    logic [15:0] rin, rout;
    logic [4:0]  op;
    int          total = 0;
    int          bad = 0;
    bit          bus_chk_on = 1'b0;

    localparam logic [17:0] RUN = 18'h1 << 17, PCOUT = 18'h1 << 16, PCIN = 18'h1 << 15,
        INCPC = 18'h1 << 14, MARIN = 18'h1 << 13, MDRIN = 18'h1 << 12, MDROUT = 18'h1 << 11,
        READ = 18'h1 << 10, IRIN = 18'h1 << 9, YIN = 18'h1 << 8, ZLIN = 18'h1 << 7,
        ZHIN = 18'h1 << 6, ZLOUT = 18'h1 << 5, ZHOUT = 18'h1 << 4, HIIN = 18'h1 << 3,
        LOIN = 18'h1 << 2, HIOUT = 18'h1 << 1, LOOUT = 18'h1;

    always #5 clk = ~clk;

    control_sequencer #(.NREG(16), .OPW(5)) dut (
        .Clock_i(clk), .Clear_i(clear), .IR_i(ir), .MemReady_i(mem_ready),
        .Run_o(run), .State_o(state), .PCout_o(pcout), .PCin_o(pcin), .IncPC_o(incpc),
        .MARin_o(marin), .MDRin_o(mdrin), .MDRout_o(mdrout), .Read_o(rd), .IRin_o(irin),
        .Yin_o(yin), .ZLowin_o(zlin), .ZHighin_o(zhin), .ZLowout_o(zlout), .ZHighout_o(zhout),
        .HIin_o(hiin), .LOin_o(loin), .HIout_o(hiout), .LOout_o(loout),
        .Rin_o(rin), .Rout_o(rout), .OP_o(op)
    );

    function automatic logic [17:0] strobes();
        return {run, pcout, pcin, incpc, marin, mdrin, mdrout, rd, irin, yin,
                zlin, zhin, zlout, zhout, hiin, loin, hiout, loout};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [3:0] st, input logic [17:0] strb,
                        input logic [15:0] e_rin, input logic [15:0] e_rout, input logic [4:0] e_op);
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".strobes"}, 32'(strobes()), 32'(strb));
        chk({tag, ".rin"}, 32'(rin), 32'(e_rin));
        chk({tag, ".rout"}, 32'(rout), 32'(e_rout));
        chk({tag, ".op"}, 32'(op), 32'(e_op));
        @(negedge clk);
    endtask

    task automatic fetch(input string tag);
        step({tag, ".T0"}, 4'd1, RUN | PCOUT | MARIN | INCPC | ZLIN, 16'h0, 16'h0, 5'b00000);
        step({tag, ".T1"}, 4'd2, RUN | ZLOUT | PCIN | READ | MDRIN, 16'h0, 16'h0, 5'b00000);
        step({tag, ".T2"}, 4'd3, RUN | MDROUT | IRIN, 16'h0, 16'h0, 5'b00000);
    endtask

    // Single-bus-driver rule, checked every cycle once reset has resolved the state.
    always @(negedge clk) begin
        if (bus_chk_on) begin
            automatic int n = int'(pcout) + int'(mdrout) + int'(zlout) + int'(zhout) +
                              int'(hiout) + int'(loout) + $countones(rout);
            total++;
            assert (n <= 1) else begin
                bad++;
                $error("FAIL bus_drivers observed=%0d expected<=1 state=%0d", n, state);
            end
        end
    end

    initial begin
        @(negedge clk);
        clear = 1'b0;
        bus_chk_on = 1'b1;
        step("rst", 4'd0, RUN, 16'h0, 16'h0, 5'b00000);

        ir = 32'h90080000;
        fetch("not");
        step("not.T3", 4'd4, RUN | ZLIN, 16'h0, 16'h0002, 5'b00010);
        step("not.T4", 4'd5, RUN | ZLOUT, 16'h0001, 16'h0, 5'b00000);

        ir = 32'h18918000;
        fetch("add");
        step("add.T3", 4'd4, RUN | YIN, 16'h0, 16'h0004, 5'b00000);
        step("add.T4", 4'd5, RUN | ZLIN, 16'h0, 16'h0008, 5'b00000);
        step("add.T5", 4'd6, RUN | ZLOUT, 16'h0002, 16'h0, 5'b00000);

        ir = 32'h78A00000;
        fetch("mul");
        step("mul.T3", 4'd4, RUN | YIN, 16'h0, 16'h0002, 5'b00000);
        step("mul.T4", 4'd5, RUN | ZLIN | ZHIN, 16'h0, 16'h0010, 5'b01000);
        step("mul.T5", 4'd6, RUN | ZLOUT | LOIN, 16'h0, 16'h0, 5'b00000);
        step("mul.T6", 4'd7, RUN | ZHOUT | HIIN, 16'h0, 16'h0, 5'b00000);

        ir = 32'h81180000;
        fetch("div");
        step("div.T3", 4'd4, RUN | YIN, 16'h0, 16'h0004, 5'b00000);
        step("div.T4", 4'd5, RUN | ZLIN | ZHIN, 16'h0, 16'h0008, 5'b01001);
        step("div.T5", 4'd6, RUN | ZLOUT | LOIN, 16'h0, 16'h0, 5'b00000);
        step("div.T6", 4'd7, RUN | ZHOUT | HIIN, 16'h0, 16'h0, 5'b00000);

        ir = 32'hD0000000;
        fetch("nop");
        ir = 32'h00000000;
        fetch("undef");
        ir = 32'h8F800000;
        fetch("neg");
        step("neg.T3", 4'd4, RUN | ZLIN, 16'h0, 16'h0001, 5'b00101);
        step("neg.T4", 4'd5, RUN | ZLOUT, 16'h8000, 16'h0, 5'b00000);

        ir = 32'h18918000;
        fetch("clr");
        step("clr.T3", 4'd4, RUN | YIN, 16'h0, 16'h0004, 5'b00000);
        clear = 1'b1;
        step("clr.T4", 4'd5, RUN | ZLIN, 16'h0, 16'h0008, 5'b00000);
        clear = 1'b0;
        step("clr.rst", 4'd0, RUN, 16'h0, 16'h0, 5'b00000);

        ir = 32'hD8000000;
        fetch("halt");
        for (int i = 0; i < 10; i++) step("halt.hold", 4'd8, 18'h0, 16'h0, 16'h0, 5'b00000);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        step("halt.rst", 4'd0, RUN, 16'h0, 16'h0, 5'b00000);
        ir = 32'hD0000000;
        step("halt.T0", 4'd1, RUN | PCOUT | MARIN | INCPC | ZLIN, 16'h0, 16'h0, 5'b00000);

`ifdef CU_MEM_WAIT_EN
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("wait.T1", 4'd2, RUN | READ | MDRIN, 16'h0, 16'h0, 5'b00000);
        mem_ready = 1'b1;
        step("wait.T1go", 4'd2, RUN | ZLOUT | PCIN | READ | MDRIN, 16'h0, 16'h0, 5'b00000);
        step("wait.T2", 4'd3, RUN | MDROUT | IRIN, 16'h0, 16'h0, 5'b00000);
        step("wait.T0", 4'd1, RUN | PCOUT | MARIN | INCPC | ZLIN, 16'h0, 16'h0, 5'b00000);
        mem_ready = 1'b0;
        clear = 1'b1;
        step("wait.clr", 4'd2, RUN | READ | MDRIN, 16'h0, 16'h0, 5'b00000);
        clear = 1'b0;
        mem_ready = 1'b1;
        step("wait.rst", 4'd0, RUN, 16'h0, 16'h0, 5'b00000);
`else
        mem_ready = 1'b0;
        step("nowait.T1", 4'd2, RUN | ZLOUT | PCIN | READ | MDRIN, 16'h0, 16'h0, 5'b00000);
        step("nowait.T2", 4'd3, RUN | MDROUT | IRIN, 16'h0, 16'h0, 5'b00000);
        mem_ready = 1'b1;
`endif

        bus_chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
